// File: rtl/ram_pkg.sv
// Shared types and constants for the RAM responder slice.
// Optional bounds checking is enabled by defining RAM_BOUNDS_EN.
package ram_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, READY} ram_state_t;
  typedef enum logic {OP_RD, OP_WR} ram_op_t;

  // Request as captured when an access starts
  typedef struct packed {
    ram_op_t     op;
    logic [31:0] addr;
    logic [31:0] data;
  } ram_req_t;

  localparam logic [31:0] RAM_BAD_DATA = 32'hBAD1BAD1;
  localparam int unsigned RAM_LAT_MAX  = 15;

endpackage

// File: rtl/ram_array.sv
// Word storage: asynchronous read, synchronous write, cleared on reset.
module ram_array #(
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic [ADDR_W-1:0] ridx,
  output logic [31:0]       rdata,
  input  logic              we,
  input  logic [ADDR_W-1:0] widx,
  input  logic [31:0]       wdata
);

  logic [31:0] mem [DEPTH];

  assign rdata = mem[ridx];

  // Single write port; reset wipes every word so a dropped access leaves no trace
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else if (we) begin
      mem[widx] <= wdata;
    end
  end

endmodule

// File: rtl/ram_responder.sv
// Responder end of the shared RAM bus: FSM, latency counter, request latch
// and optional bounds check (RAM_BOUNDS_EN) around a ram_array.
module ram_responder
  import ram_pkg::*;
#(
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned LAT    = 2,
  localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        Ren,
  input  logic        Wen,
  input  logic [31:0] ramaddr,
  input  logic [31:0] ramstore,
  output logic [31:0] ramload,
  output logic        busy_o
);

  ram_state_t        state, state_nxt;
  logic [3:0]        cnt;
  ram_req_t          lat_q;
  logic              req_vld, match, complete, oob, we;
  ram_op_t           cur_op;
  logic [ADDR_W-1:0] idx;
  logic [31:0]       rdata;
  logic              unused_lat_data;

  // Both-high is the bus idle code, both-low is no request
  assign req_vld = Ren ^ Wen;
  assign cur_op  = Wen ? OP_WR : OP_RD;
  assign idx     = ramaddr[ADDR_W+1:2];
  assign match   = req_vld && (cur_op == lat_q.op) && (ramaddr == lat_q.addr);

  // Latched write data is kept for the record; completion samples ramstore live
  assign unused_lat_data = ^lat_q.data;

`ifdef RAM_BOUNDS_EN
  assign oob = |ramaddr[31:ADDR_W+2];
`else
  assign oob = 1'b0;
`endif

  assign complete = ((state == IDLE) && (LAT == 0) && req_vld) ||
                    ((state == READY) && match);
  assign we       = complete && (cur_op == OP_WR) && !oob;

  ram_array #(.DEPTH(DEPTH)) u_array (
    .CLK   (CLK),
    .nRST  (nRST),
    .ridx  (idx),
    .rdata (rdata),
    .we    (we),
    .widx  (idx),
    .wdata (ramstore)
  );

  // State register
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state: any mismatch while pending aborts back to IDLE
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (req_vld && (LAT == 1))      state_nxt = READY;
        else if (req_vld && (LAT >= 2)) state_nxt = WAIT;
      end
      WAIT: begin
        if (!match)        state_nxt = IDLE;
        else if (cnt == 1) state_nxt = READY;
      end
      READY:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs: busy drops only in a completion cycle; load is zero unless a read completes
  always_comb begin
    busy_o  = 1'b0;
    ramload = '0;
    unique case (state)
      IDLE:    busy_o = (LAT != 0) && req_vld;
      WAIT:    busy_o = 1'b1;
      READY:   busy_o = !match;
      default: busy_o = 1'b0;
    endcase
    if (complete && (cur_op == OP_RD)) ramload = oob ? RAM_BAD_DATA : rdata;
  end

  // Request latch and latency counter, loaded when an access starts in IDLE
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      cnt   <= '0;
      lat_q <= '0;
    end else if ((state == IDLE) && req_vld && (LAT != 0)) begin
      lat_q <= '{op: cur_op, addr: ramaddr, data: ramstore};
      if (LAT >= 2) cnt <= 4'(LAT - 1);
    end else if ((state == WAIT) && match && (cnt != 1)) begin
      cnt <= cnt - 4'd1;
    end
  end

endmodule

// File: tb/tb_ram_responder.sv
// Directed bench: three responders (LAT 2, 0, 3) share one stimulus bus;
// each scenario checks only the instance it targets.
module tb_ram_responder;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        Ren, Wen;
  logic [31:0] ramaddr, ramstore;
  logic [31:0] ld2, ld0, ld3;
  logic        bz2, bz0, bz3;
  int          errs = 0;
  int          checks = 0;

  always #5 CLK = ~CLK;

  ram_responder #(.DEPTH(1024), .LAT(2)) u_l2 (
    .CLK(CLK), .nRST(nRST), .Ren(Ren), .Wen(Wen), .ramaddr(ramaddr),
    .ramstore(ramstore), .ramload(ld2), .busy_o(bz2));
  ram_responder #(.DEPTH(1024), .LAT(0)) u_l0 (
    .CLK(CLK), .nRST(nRST), .Ren(Ren), .Wen(Wen), .ramaddr(ramaddr),
    .ramstore(ramstore), .ramload(ld0), .busy_o(bz0));
  ram_responder #(.DEPTH(1024), .LAT(3)) u_l3 (
    .CLK(CLK), .nRST(nRST), .Ren(Ren), .Wen(Wen), .ramaddr(ramaddr),
    .ramstore(ramstore), .ramload(ld3), .busy_o(bz3));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic drv(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    Ren = r; Wen = w; ramaddr = a; ramstore = d;
  endtask

  // Advance to just after the next rising edge (inputs change here)
  task automatic nxt();
    @(posedge CLK); #1;
  endtask

  // Sample point, away from the active edge
  task automatic smp();
    @(negedge CLK);
  endtask

  initial begin
    nRST = 1'b0;
    drv(0, 0, 32'h0, 32'h0);
    nxt(); nxt();
    smp();
    chk("rst_busy2", 32'(bz2), 32'd0);
    chk("rst_load2", ld2, 32'h0);
    chk("rst_busy3", 32'(bz3), 32'd0);
    nxt();
    nRST = 1'b1;
    nxt();

    // 1: LAT=2 write 0x40 held, then read it back
    drv(0, 1, 32'h40, 32'hDEADBEEF);
    smp(); chk("t1_wr_busy_c0", 32'(bz2), 32'd1); nxt();
    smp(); chk("t1_wr_busy_c1", 32'(bz2), 32'd1); nxt();
    smp(); chk("t1_wr_busy_c2", 32'(bz2), 32'd0);
           chk("t1_wr_load_c2", ld2, 32'h0); nxt();
    drv(1, 0, 32'h40, 32'h0);
    smp(); chk("t1_rd_busy_c0", 32'(bz2), 32'd1);
           chk("t1_rd_load_c0", ld2, 32'h0); nxt();
    smp(); chk("t1_rd_load_c1", ld2, 32'h0); nxt();
    smp(); chk("t1_rd_busy_c2", 32'(bz2), 32'd0);
           chk("t1_rd_load_c2", ld2, 32'hDEADBEEF); nxt();

    // 2: LAT=2 read 0x40, switch to 0x44 in cycle 1 -> abort then restart
    drv(1, 0, 32'h40, 32'h0);
    smp(); chk("t2_busy_c0", 32'(bz2), 32'd1); nxt();
    drv(1, 0, 32'h44, 32'h0);
    smp(); chk("t2_busy_c1", 32'(bz2), 32'd1);
           chk("t2_load_c1", ld2, 32'h0); nxt();
    smp(); chk("t2_busy_c2", 32'(bz2), 32'd1); nxt();
    smp(); chk("t2_busy_c3", 32'(bz2), 32'd1); nxt();
    smp(); chk("t2_busy_c4", 32'(bz2), 32'd0);
           chk("t2_load_c4", ld2, 32'h0); nxt();

    // 3: idle code for 5 cycles, then read word 0
    drv(1, 1, 32'h0, 32'hFFFFFFFF);
    for (int i = 0; i < 5; i++) begin
      smp(); chk($sformatf("t3_idle_busy%0d", i), 32'(bz2), 32'd0);
             chk($sformatf("t3_idle_load%0d", i), ld2, 32'h0);
      nxt();
    end
    drv(1, 0, 32'h0, 32'h0);
    nxt(); nxt();
    smp(); chk("t3_rd0_busy", 32'(bz2), 32'd0);
           chk("t3_rd0_load", ld2, 32'h0); nxt();

    // 4: LAT=0 write 0x8 then read 0x8 next cycle
    drv(0, 1, 32'h8, 32'h12345678);
    smp(); chk("t4_wr_busy", 32'(bz0), 32'd0);
           chk("t4_wr_load", ld0, 32'h0); nxt();
    drv(1, 0, 32'h8, 32'h0);
    smp(); chk("t4_rd_busy", 32'(bz0), 32'd0);
           chk("t4_rd_load", ld0, 32'h12345678); nxt();
    drv(0, 0, 32'h0, 32'h0);
    smp(); chk("t4_noreq_load", ld0, 32'h0); nxt();

    // 6: LAT=2 out-of-range address 0x1000
    drv(1, 0, 32'h1000, 32'h0);
    nxt(); nxt();
`ifdef RAM_BOUNDS_EN
    smp(); chk("t6_oob_rd", ld2, 32'hBAD1BAD1);
`else
    smp(); chk("t6_wrap_rd", ld2, 32'h0);
`endif
           chk("t6_rd_busy", 32'(bz2), 32'd0); nxt();
    drv(0, 1, 32'h1000, 32'h5);
    nxt(); nxt();
    smp(); chk("t6_wr_busy", 32'(bz2), 32'd0); nxt();
    drv(1, 0, 32'h0, 32'h0);
    nxt(); nxt();
`ifdef RAM_BOUNDS_EN
    smp(); chk("t6_word0_kept", ld2, 32'h0);
`else
    smp(); chk("t6_word0_wrapped", ld2, 32'h5);
`endif
    nxt();

    // 5: LAT=3 write 0x10, reset in cycle 2, then read 0x10
    drv(0, 1, 32'h10, 32'hAAAA5555);
    smp(); chk("t5_busy_c0", 32'(bz3), 32'd1); nxt();
    smp(); chk("t5_busy_c1", 32'(bz3), 32'd1); nxt();
    nRST = 1'b0;
    drv(0, 0, 32'h0, 32'h0);
    smp(); chk("t5_rst_busy", 32'(bz3), 32'd0);
           chk("t5_rst_load", ld3, 32'h0); nxt();
    nRST = 1'b1;
    drv(1, 0, 32'h10, 32'h0);
    smp(); chk("t5_rd_busy_c0", 32'(bz3), 32'd1); nxt();
    smp(); chk("t5_rd_busy_c1", 32'(bz3), 32'd1); nxt();
    smp(); chk("t5_rd_busy_c2", 32'(bz3), 32'd1); nxt();
    smp(); chk("t5_rd_busy_c3", 32'(bz3), 32'd0);
           chk("t5_rd_load_c3", ld3, 32'h0); nxt();
    drv(0, 0, 32'h0, 32'h0);
    nxt();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
